// File: rtl/memory_arbiter_if.sv
// ----------------------------------------------------------------------------
// memory_arbiter_if
//
// Purpose: the bus signals around the instruction/data memory arbiter. This
// covers the CPU instruction port, the CPU data port and the shared memory port.
//
// Handshake semantics (all three ports):
//   - A requester raises *_valid with its fields stable. It holds them until
//     it sees *_ready=1. It may drop the request before the grant; a dropped
//     request is never serviced.
//   - *_ready is a single-cycle completion pulse. *_rdata is meaningful only
//     while the matching *_ready is 1.
//   - memory_valid is presented for exactly one cycle per transaction, and
//     memory_ready is returned exactly one cycle after that valid cycle.
//
// Modports:
//   slave  - arbiter view: it serves the CPU ports and drives the memory port.
//   master - environment view: the CPU plus memory side, all directions reversed.
// ----------------------------------------------------------------------------
interface memory_arbiter_if;
    // instruction port
    logic        imem_valid;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    // data port
    logic        dmem_valid;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    // shared memory port
    logic        memory_valid;
    logic        memory_instr;
    logic [31:0] memory_addr;
    logic [31:0] memory_wdata;
    logic [3:0]  memory_wstrb;
    logic [31:0] memory_rdata;
    logic        memory_ready;

    modport slave (
        input  imem_valid, imem_addr,
        output imem_rdata, imem_ready,
        input  dmem_valid, dmem_addr, dmem_wdata, dmem_wstrb,
        output dmem_rdata, dmem_ready,
        output memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb,
        input  memory_rdata, memory_ready
    );

    modport master (
        output imem_valid, imem_addr,
        input  imem_rdata, imem_ready,
        output dmem_valid, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dmem_rdata, dmem_ready,
        input  memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb,
        output memory_rdata, memory_ready
    );
endinterface

// File: rtl/memory_arbiter.sv
// ----------------------------------------------------------------------------
// memory_arbiter
//
// Purpose: shares one single-outstanding memory port between an instruction
// requester and a data requester. A grant is issued combinationally in IDLE.
// The winner's ready pulse comes on the following cycle, when memory answers.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active-low (0 = reset)
//   bus          memory_arbiter_if.slave (imem, dmem and memory ports)
//   o_dbg_state  current FSM state (0 = IDLE, 1 = BUSY_I, 2 = BUSY_D)
//
// Configuration:
//   ARBITER_ROUND_ROBIN_EN  defined   -> on simultaneous requests, the port not
//                                        granted most recently wins; after
//                                        reset, data wins first.
//                           undefined -> fixed priority, data beats instruction.
// ----------------------------------------------------------------------------
module memory_arbiter (
    input  logic              clk,
    input  logic              rst,
    memory_arbiter_if.slave   bus,
    output logic [1:0]        o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;
    logic   w_grant_d;

`ifdef ARBITER_ROUND_ROBIN_EN
    // 1 = the most recent grant went to the instruction port.
    logic r_last_i;
    logic w_issue;
    logic w_issue_i;

    assign w_grant_d = bus.dmem_valid && (!bus.imem_valid || r_last_i);
    assign w_issue   = rst && (r_state == IDLE) && (bus.imem_valid || bus.dmem_valid);
    assign w_issue_i = w_issue && !w_grant_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last_i <= 1'b1;
        end else if (w_issue) begin
            r_last_i <= w_issue_i;
        end
    end
`else
    assign w_grant_d = bus.dmem_valid;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state      = r_state;
        bus.memory_valid  = 1'b0;
        bus.memory_instr  = 1'b0;
        bus.memory_addr   = 32'h0;
        bus.memory_wdata  = 32'h0;
        bus.memory_wstrb  = 4'h0;
        bus.imem_ready    = 1'b0;
        bus.dmem_ready    = 1'b0;
        // Read data is a plain pass-through and is qualified only by ready.
        bus.imem_rdata    = bus.memory_rdata;
        bus.dmem_rdata    = bus.memory_rdata;

        case (r_state)
            IDLE: begin
                // memory_ready is ignored here. Nothing is issued while rst is
                // held low.
                if (rst && w_grant_d) begin
                    bus.memory_valid = 1'b1;
                    bus.memory_addr  = bus.dmem_addr;
                    bus.memory_wdata = bus.dmem_wdata;
                    bus.memory_wstrb = bus.dmem_wstrb;
                    w_next_state     = BUSY_D;
                end else if (rst && bus.imem_valid) begin
                    bus.memory_valid = 1'b1;
                    bus.memory_instr = 1'b1;
                    bus.memory_addr  = bus.imem_addr;
                    w_next_state     = BUSY_I;
                end
            end
            BUSY_I: begin
                if (rst && bus.memory_ready) begin
                    bus.imem_ready = 1'b1;
                    w_next_state   = IDLE;
                end
            end
            BUSY_D: begin
                if (rst && bus.memory_ready) begin
                    bus.dmem_ready = 1'b1;
                    w_next_state   = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  dbg_state;

    memory_arbiter_if bus();

    // Memory model: answers one cycle after each valid cycle.
    // Read data is 0x13 at address 0x10, otherwise address + 0x100.
    logic        mem_pend;
    logic [31:0] mem_data;
    logic        mem_block;
    logic        force_rdy;

    int n_total;
    int n_bad;

    memory_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_pend <= bus.memory_valid;
        mem_data <= (bus.memory_addr == 32'h10) ? 32'h13 : bus.memory_addr + 32'h100;
    end

    assign bus.memory_ready = (mem_pend & ~mem_block) | force_rdy;
    assign bus.memory_rdata = mem_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge and outputs are sampled 2
    // time units later, well before the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        mem_pend  = 1'b0;
        mem_data  = 32'h0;
        mem_block = 1'b0;
        force_rdy = 1'b0;
        rst = 1'b0;
        bus.imem_valid = 1'b1;
        bus.imem_addr  = 32'h10;
        bus.dmem_valid = 1'b0;
        bus.dmem_addr  = 32'h0;
        bus.dmem_wdata = 32'h0;
        bus.dmem_wstrb = 4'h0;

        // Reset: a pending request must not be issued while rst=0.
        step();
        step();
        settle();
        chk("rst_state", {30'h0, dbg_state}, 32'd0);
        chk("rst_mem_valid", {31'h0, bus.memory_valid}, 32'd0);
        chk("rst_imem_ready", {31'h0, bus.imem_ready}, 32'd0);
        chk("rst_dmem_ready", {31'h0, bus.dmem_ready}, 32'd0);

        // The request dropped before any grant is simply never serviced.
        step();
        bus.imem_valid = 1'b0;
        rst = 1'b1;
        settle();
        chk("drop_no_valid", {31'h0, bus.memory_valid}, 32'd0);

        // Instruction fetch from 0x10 returns 0x13.
        step();
        bus.imem_valid = 1'b1;
        bus.imem_addr  = 32'h10;
        settle();
        chk("if_valid", {31'h0, bus.memory_valid}, 32'd1);
        chk("if_instr", {31'h0, bus.memory_instr}, 32'd1);
        chk("if_addr", bus.memory_addr, 32'h10);
        chk("if_wstrb", {28'h0, bus.memory_wstrb}, 32'd0);
        chk("if_wdata", bus.memory_wdata, 32'd0);
        chk("if_early_ready", {31'h0, bus.imem_ready}, 32'd0);
        step();
        settle();
        chk("if_busy_state", {30'h0, dbg_state}, 32'd1);
        chk("if_no_dup", {31'h0, bus.memory_valid}, 32'd0);
        chk("if_ready", {31'h0, bus.imem_ready}, 32'd1);
        chk("if_rdata", bus.imem_rdata, 32'h13);
        chk("if_dmem_ready", {31'h0, bus.dmem_ready}, 32'd0);
        step();
        bus.imem_valid = 1'b0;
        settle();
        chk("if_back_idle", {30'h0, dbg_state}, 32'd0);
        chk("if_ready_pulse", {31'h0, bus.imem_ready}, 32'd0);

        // Store of 0x1 to 0x1000 with all byte strobes set.
        bus.dmem_valid = 1'b1;
        bus.dmem_addr  = 32'h1000;
        bus.dmem_wdata = 32'h1;
        bus.dmem_wstrb = 4'hF;
        settle();
        chk("st_valid", {31'h0, bus.memory_valid}, 32'd1);
        chk("st_instr", {31'h0, bus.memory_instr}, 32'd0);
        chk("st_addr", bus.memory_addr, 32'h1000);
        chk("st_wdata", bus.memory_wdata, 32'h1);
        chk("st_wstrb", {28'h0, bus.memory_wstrb}, 32'hF);
        step();
        settle();
        chk("st_no_dup", {31'h0, bus.memory_valid}, 32'd0);
        chk("st_idle_wstrb", {28'h0, bus.memory_wstrb}, 32'd0);
        chk("st_ready", {31'h0, bus.dmem_ready}, 32'd1);
        chk("st_imem_ready", {31'h0, bus.imem_ready}, 32'd0);
        step();
        bus.dmem_valid = 1'b0;
        bus.dmem_wstrb = 4'h0;
        bus.dmem_wdata = 32'h0;
        settle();
        chk("st_ready_pulse", {31'h0, bus.dmem_ready}, 32'd0);

        // Back-to-back loads from 0x0 then 0x4: valid at t and t+2, ready at t+1 and t+3.
        bus.dmem_valid = 1'b1;
        bus.dmem_addr  = 32'h0;
        settle();
        chk("ld0_valid", {31'h0, bus.memory_valid}, 32'd1);
        chk("ld0_addr", bus.memory_addr, 32'h0);
        step();
        settle();
        chk("ld0_ready", {31'h0, bus.dmem_ready}, 32'd1);
        chk("ld0_rdata", bus.dmem_rdata, 32'h100);
        chk("ld0_busy_valid", {31'h0, bus.memory_valid}, 32'd0);
        step();
        bus.dmem_addr = 32'h4;
        settle();
        chk("ld1_valid", {31'h0, bus.memory_valid}, 32'd1);
        chk("ld1_addr", bus.memory_addr, 32'h4);
        chk("ld1_gap_ready", {31'h0, bus.dmem_ready}, 32'd0);
        step();
        settle();
        chk("ld1_ready", {31'h0, bus.dmem_ready}, 32'd1);
        chk("ld1_rdata", bus.dmem_rdata, 32'h104);
        step();
        bus.dmem_valid = 1'b0;

        // Fresh reset, then both ports request continuously for 8 grants.
        rst = 1'b0;
        step();
        rst = 1'b1;
        bus.imem_valid = 1'b1;
        bus.imem_addr  = 32'h20;
        bus.dmem_valid = 1'b1;
        bus.dmem_addr  = 32'h40;
        for (int g = 0; g < 8; g++) begin
            logic exp_i;
`ifdef ARBITER_ROUND_ROBIN_EN
            exp_i = (g % 2) == 1;
`else
            exp_i = 1'b0;
`endif
            settle();
            chk($sformatf("both_g%0d_valid", g), {31'h0, bus.memory_valid}, 32'd1);
            chk($sformatf("both_g%0d_instr", g), {31'h0, bus.memory_instr}, {31'h0, exp_i});
            chk($sformatf("both_g%0d_addr", g), bus.memory_addr, exp_i ? 32'h20 : 32'h40);
            step();
            settle();
            chk($sformatf("both_g%0d_iready", g), {31'h0, bus.imem_ready}, {31'h0, exp_i});
            chk($sformatf("both_g%0d_dready", g), {31'h0, bus.dmem_ready}, {31'h0, ~exp_i});
            step();
        end
        bus.imem_valid = 1'b0;
        bus.dmem_valid = 1'b0;

        // Reset asserted while BUSY_D; the late memory_ready must be discarded.
        bus.dmem_valid = 1'b1;
        bus.dmem_addr  = 32'h8;
        settle();
        chk("abort_grant", {31'h0, bus.memory_valid}, 32'd1);
        step();
        mem_block = 1'b1;
        rst = 1'b0;
        bus.dmem_valid = 1'b0;
        settle();
        chk("abort_busy_state", {30'h0, dbg_state}, 32'd2);
        chk("abort_no_ready_in_rst", {31'h0, bus.dmem_ready}, 32'd0);
        step();
        rst = 1'b1;
        mem_block = 1'b0;
        force_rdy = 1'b1;
        settle();
        chk("abort_state_idle", {30'h0, dbg_state}, 32'd0);
        chk("abort_no_dready", {31'h0, bus.dmem_ready}, 32'd0);
        chk("abort_no_iready", {31'h0, bus.imem_ready}, 32'd0);
        chk("abort_mem_valid", {31'h0, bus.memory_valid}, 32'd0);

        // memory_ready stuck high while IDLE with no requests.
        step();
        settle();
        chk("idle_rdy_state", {30'h0, dbg_state}, 32'd0);
        chk("idle_rdy_iready", {31'h0, bus.imem_ready}, 32'd0);
        chk("idle_rdy_dready", {31'h0, bus.dmem_ready}, 32'd0);
        chk("idle_rdy_valid", {31'h0, bus.memory_valid}, 32'd0);
        step();
        force_rdy = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
- Parameters: none; widths fixed at 32-bit address/data, 4-bit strobe.
- REQ-001 SHALL have ports: clk  input  1  rising-edge clock.
- REQ-002 SHALL have: rst  input  1  synchronous reset, active-low (0 = reset).
- REQ-003 SHALL have: imem_valid  input  1  instruction request, held high until imem_ready.
- REQ-004 SHALL have: imem_addr  input  32  instruction byte address.
- REQ-005 SHALL have: imem_rdata  output  32  instruction read data, valid when imem_ready=1.
- REQ-006 SHALL have: imem_ready  output  1  one-cycle instruction completion pulse.
- REQ-007 SHALL have: dmem_valid  input  1  data request, held high until dmem_ready.
- REQ-008 SHALL have: dmem_addr  input  32  data byte address.
- REQ-009 SHALL have: dmem_wdata  input  32  store data.
- REQ-010 SHALL have: dmem_wstrb  input  4  byte write strobes; 0 = load.
- REQ-011 SHALL have: dmem_rdata  output  32  load data, valid when dmem_ready=1.
- REQ-012 SHALL have: dmem_ready  output  1  one-cycle data completion pulse.
- REQ-013 SHALL have: memory_valid, memory_instr (1), memory_addr, memory_wdata (32), memory_wstrb (4)  outputs  shared-memory request.
- REQ-014 SHALL have: memory_rdata  input  32; memory_ready  input  1; memory returns ready exactly one cycle after a valid cycle.

Function
- REQ-015 FSM states IDLE, BUSY_I, BUSY_D; one outstanding memory transaction maximum.
- REQ-016 IDLE, any request pending: drive memory_valid=1 combinationally for that cycle only, with the winner's fields; next state BUSY_I or BUSY_D.
- REQ-017 Instruction grant: memory_instr=1, memory_addr=imem_addr, memory_wdata=0, memory_wstrb=0.
- REQ-018 Data grant: memory_instr=0, memory_addr/wdata/wstrb = dmem fields unmodified.
- REQ-019 Not issuing: memory_valid=0, memory_wstrb=0, other memory outputs 0; a request is never presented for two cycles (no duplicate stores).
- REQ-020 BUSY_x: on memory_ready=1, pulse x_ready=1 for one cycle with x_rdata=memory_rdata, return to IDLE; otherwise remain.
- REQ-021 Non-owner ready stays 0; both rdata outputs equal memory_rdata, qualified only by their ready.
- REQ-022 memory_ready in IDLE SHALL be ignored.
- REQ-023 Latency: request granted in IDLE at cycle t -> requester ready at t+1; next grant earliest t+2 (2-cycle throughput).
- REQ-024 Request dropping in IDLE before grant is legal and simply not serviced.
- REQ-025 Simultaneous requests: arbitration per REQ-030/031.

Reset
- REQ-026 While rst=0 at a clock edge: state IDLE, last-grant register = instruction, all outputs 0 next cycle.
- REQ-027 Reset in BUSY_x aborts the transaction; the trailing memory_ready is discarded, no x_ready pulse.
- REQ-028 memory_valid SHALL be 0 during any cycle with rst=0.

Configuration
- REQ-029 Macro ARBITER_ROUND_ROBIN_EN selects arbitration policy.
- REQ-030 Defined: on simultaneous requests grant the port not granted most recently; last-grant updates on every grant; reset value makes data win first.
- REQ-031 Undefined: fixed priority, data always beats instruction; last-grant register absent.

Verification
- REQ-032 Reset, imem_valid=1 addr 0x0000_0010, mem returns 0x0000_0013 -> memory_valid one cycle, memory_instr=1, wstrb=0; imem_ready one cycle later with rdata 0x13.
- REQ-033 dmem store addr 0x1000, wdata 0x1, wstrb 0xF -> exactly one memory_valid cycle, wstrb 0xF, dmem_ready next cycle, imem_ready stays 0.
- REQ-034 Both valid continuously 8 grants -> with macro alternating D,I,D,I...; without, all D, imem starved.
- REQ-035 Back-to-back dmem loads 0x0, 0x4 -> memory_valid at t and t+2, dmem_ready at t+1 and t+3.
- REQ-036 rst=0 asserted in BUSY_D, memory_ready=1 next cycle -> no dmem_ready, state IDLE, memory_valid=0.
- REQ-037 memory_ready forced 1 while IDLE, no requests -> imem_ready=dmem_ready=0.
